// File: rtl/bus_target_sm_if.sv
// Bus-side signal bundle for the 68030 bus target state machine.
// The master modport is the bus/CPU side; the slave modport is the target.
interface bus_target_sm_if;
    // Bus strobes and qualifiers from the CPU side
    logic AS_;
    logic DS_;
    logic R_W;
    logic CS_;
    logic EXT;
    logic DEV_RDY;

    // Target responses and local strobes
    logic DSACK0_;
    logic DSACK1_;
    logic DSACK_OE;
    logic BERR_;
    logic RD_STB;
    logic WR_STB;
    logic DLATCH;
    logic DOE;

    modport master (
        output AS_, DS_, R_W, CS_, EXT, DEV_RDY,
        input  DSACK0_, DSACK1_, DSACK_OE, BERR_, RD_STB, WR_STB, DLATCH, DOE
    );

    modport slave (
        input  AS_, DS_, R_W, CS_, EXT, DEV_RDY,
        output DSACK0_, DSACK1_, DSACK_OE, BERR_, RD_STB, WR_STB, DLATCH, DOE
    );
endinterface

// File: rtl/bus_target_sm.sv
// 68030 asynchronous bus target: synchronizes the bus strobes, issues
// register strobes, inserts fixed or device-paced wait states, and answers
// with a 32-bit DSACK or a bus error. All outputs come straight from flops.
module bus_target_sm #(
    parameter int WAIT_STATES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic           CLK,
    input  logic           RESET,
    bus_target_sm_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        ACK,
        ERR,
        RELEASE
    } state_t;

    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    // Two-flop synchronizer stages; *_s is the only copy the FSM looks at
    logic as_s1, as_s;
    logic ds_s1, ds_s;
    logic cs_s1, cs_s;
    logic rw_s1, rw_s;

    state_t     state, state_nx;
    logic       rw_q, rw_nx;
    logic       ext_q, ext_nx;
    logic [3:0] ws_cnt, ws_nx;
    logic [7:0] to_cnt, to_nx;

    logic dsack_q, dsack_nx;
    logic berr_q, berr_nx;
    logic oe_q, oe_nx;
    logic rd_q, rd_nx;
    logic wr_q, wr_nx;
    logic dl_q, dl_nx;
    logic doe_q, doe_nx;

    // Bring the asynchronous bus strobes into the CLK domain (idle = negated)
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            as_s1 <= 1'b1;
            as_s  <= 1'b1;
            ds_s1 <= 1'b1;
            ds_s  <= 1'b1;
            cs_s1 <= 1'b1;
            cs_s  <= 1'b1;
            rw_s1 <= 1'b1;
            rw_s  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its neighbour, which is what turns this into a chain.
            as_s1 <= bus.AS_;
            as_s  <= as_s1;
            ds_s1 <= bus.DS_;
            ds_s  <= ds_s1;
            cs_s1 <= bus.CS_;
            cs_s  <= cs_s1;
            rw_s1 <= bus.R_W;
            rw_s  <= rw_s1;
        end
    end

    // State, captured cycle attributes, counters and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            rw_q    <= 1'b1;
            ext_q   <= 1'b0;
            ws_cnt  <= '0;
            to_cnt  <= '0;
            dsack_q <= 1'b1;
            berr_q  <= 1'b1;
            oe_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            dl_q    <= 1'b0;
            doe_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            rw_q    <= rw_nx;
            ext_q   <= ext_nx;
            ws_cnt  <= ws_nx;
            to_cnt  <= to_nx;
            dsack_q <= dsack_nx;
            berr_q  <= berr_nx;
            oe_q    <= oe_nx;
            rd_q    <= rd_nx;
            wr_q    <= wr_nx;
            dl_q    <= dl_nx;
            doe_q   <= doe_nx;
        end
    end

    // Next-state decision; outputs are derived from the state being entered
    // so that they can be registered without adding a cycle of latency
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nx = state;
        rw_nx    = rw_q;
        ext_nx   = ext_q;
        ws_nx    = ws_cnt;
        to_nx    = to_cnt;

        case (state)
            IDLE: begin
                if (!as_s && !cs_s && (rw_s || !ds_s)) begin
                    state_nx = START;
                    rw_nx    = rw_s;
                    ext_nx   = bus.EXT;
                end
            end
            START: begin
                if (as_s) begin
                    state_nx = RELEASE;
                end else if (ext_q) begin
                    state_nx = WAIT;
                    to_nx    = 8'd1;
                end else if (WS_CNT == 4'd0) begin
                    state_nx = ACK;
                end else begin
                    state_nx = WAIT;
                    ws_nx    = WS_CNT;
                end
            end
            WAIT: begin
                if (as_s) begin
                    state_nx = RELEASE;
                end else if (ext_q) begin
                    // Device ready wins over a timeout reached in the same cycle
                    if (bus.DEV_RDY) begin
                        state_nx = ACK;
                    end else if (to_cnt == TO_CNT) begin
                        state_nx = ERR;
                    end else begin
                        to_nx = 8'(to_cnt + 8'd1);
                    end
                end else if (ws_cnt <= 4'd1) begin
                    state_nx = ACK;
                end else begin
                    ws_nx = ws_cnt - 4'd1;
                end
            end
            ACK, ERR: begin
                if (as_s) begin
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        dsack_nx = 1'b1;
        berr_nx  = 1'b1;
        oe_nx    = 1'b0;
        rd_nx    = 1'b0;
        wr_nx    = 1'b0;
        dl_nx    = 1'b0;
        doe_nx   = 1'b0;

        case (state_nx)
            START: begin
                rd_nx  = rw_nx;
                wr_nx  = !rw_nx;
                dl_nx  = !rw_nx;
                doe_nx = rw_nx;
            end
            WAIT: begin
                doe_nx = rw_nx;
            end
            ACK: begin
                dsack_nx = 1'b0;
                oe_nx    = 1'b1;
                doe_nx   = rw_nx;
            end
            ERR: begin
                berr_nx = 1'b0;
                oe_nx   = 1'b1;
            end
            RELEASE: begin
                // Drive the pins high for one cycle before letting them float
                oe_nx = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.DSACK0_  = dsack_q;
    assign bus.DSACK1_  = dsack_q;
    assign bus.BERR_    = berr_q;
    assign bus.DSACK_OE = oe_q;
    assign bus.RD_STB   = rd_q;
    assign bus.WR_STB   = wr_q;
    assign bus.DLATCH   = dl_q;
    assign bus.DOE      = doe_q;

endmodule

// File: tb/tb_bus_target_sm.sv
// Self-checking bench for bus_target_sm. Each bus cycle is described by the
// edge numbers at which START, the terminal state and RELEASE must occur,
// worked out from the cycle's timing parameters; every output is then
// compared against that timeline on every clock.
module tb_bus_target_sm;

    localparam int WS = 2;
    localparam int TO = 8;

    // Output vector order: DSACK0_, DSACK1_, BERR_, DSACK_OE, RD_STB, WR_STB, DLATCH, DOE
    localparam logic [7:0] O_IDLE = 8'b1110_0000;
    localparam logic [7:0] O_REL  = 8'b1111_0000;
    localparam logic [7:0] O_ERR  = 8'b1101_0000;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    bus_target_sm_if bus ();

    bus_target_sm #(
        .WAIT_STATES(WS),
        .TIMEOUT    (TO)
    ) u_dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] outs();
        return {bus.DSACK0_, bus.DSACK1_, bus.BERR_, bus.DSACK_OE,
                bus.RD_STB, bus.WR_STB, bus.DLATCH, bus.DOE};
    endfunction

    task automatic drive_idle();
        bus.AS_     = 1'b1;
        bus.DS_     = 1'b1;
        bus.CS_     = 1'b1;
        bus.R_W     = 1'b1;
        bus.EXT     = 1'b0;
        bus.DEV_RDY = 1'b0;
    endtask

    // One bus cycle. Edge 1 is the first clock after AS_/CS_ fall.
    //   rd        : 1 = read, 0 = write
    //   d         : write only, DS_ falls d clocks after AS_
    //   ext       : external access paced by DEV_RDY
    //   rdy_at    : DEV_RDY goes high in this WAIT cycle (1-based), 0 = never
    //   abort     : negate AS_ before the cycle terminates
    //   abort_sel : picks where the abort lands
    //   hold      : extra clocks AS_ stays low after the terminal state
    //   tail      : clocks checked after RELEASE begins
    task automatic run_txn(input string name, input bit rd, input int d,
                           input bit ext, input int rdy_at, input bit abort,
                           input int abort_sel, input int hold, input int tail);
        int s_e, a_e, r_e;
        bit err;
        logic [7:0] exp_v, got_v;

        s_e = 3 + (rd ? 0 : d);
        if (!ext) begin
            a_e = s_e + 1 + WS;
            err = 1'b0;
        end else if (rdy_at >= 1 && rdy_at <= TO) begin
            a_e = s_e + rdy_at + 1;
            err = 1'b0;
        end else begin
            a_e = s_e + TO + 1;
            err = 1'b1;
        end
        if (abort) r_e = s_e - 1 + (abort_sel % (a_e - s_e));
        else       r_e = a_e + hold;

        for (int e = 1; e <= r_e + 2 + tail; e++) begin
            @(negedge CLK);
            bus.AS_     = !(e < r_e);
            bus.CS_     = !(e < r_e);
            bus.DS_     = !(e < r_e && (rd || e >= 1 + d));
            bus.R_W     = rd;
            bus.EXT     = ext;
            bus.DEV_RDY = ext && rdy_at > 0 && e >= s_e + rdy_at + 1;
            @(posedge CLK);
            #1;
            if (e == s_e)
                exp_v = {4'b1110, rd, !rd, !rd, rd};
            else if (e > s_e && e < a_e && e < r_e + 2)
                exp_v = {4'b1110, 3'b000, rd};
            else if (e > s_e && e >= a_e && e < r_e + 2)
                exp_v = err ? O_ERR : {4'b0011, 3'b000, rd};
            else if (e == r_e + 2)
                exp_v = O_REL;
            else
                exp_v = O_IDLE;
            got_v = outs();
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s edge=%0d got=%b expected=%b", name, e, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        #2 RESET = 1'b1;
        #1;
        n_tests++;
        if (outs() !== O_IDLE) begin
            n_fail++;
            $display("FAIL reset_async got=%b expected=%b", outs(), O_IDLE);
        end
        // Strobes asserted while reset is held must not start anything
        bus.AS_ = 1'b0;
        bus.CS_ = 1'b0;
        bus.DS_ = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
            n_tests++;
            if (outs() !== O_IDLE) begin
                n_fail++;
                $display("FAIL reset_held got=%b expected=%b", outs(), O_IDLE);
            end
        end
        @(negedge CLK);
        drive_idle();
        RESET = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            n_tests++;
            if (outs() !== O_IDLE) begin
                n_fail++;
                $display("FAIL reset_release got=%b expected=%b", outs(), O_IDLE);
            end
        end
    endtask

    task automatic test_internal_read();
        run_txn("int_read", 1'b1, 0, 1'b0, 0, 1'b0, 0, 2, 2);
    endtask

    task automatic test_internal_write();
        run_txn("int_write_ds2", 1'b0, 2, 1'b0, 0, 1'b0, 0, 1, 2);
        run_txn("int_write_ds0", 1'b0, 0, 1'b0, 0, 1'b0, 0, 0, 2);
    endtask

    task automatic test_ext_read();
        run_txn("ext_read_rdy6", 1'b1, 0, 1'b1, 6, 1'b0, 0, 1, 2);
        run_txn("ext_write_rdy1", 1'b0, 1, 1'b1, 1, 1'b0, 0, 0, 2);
    endtask

    task automatic test_timeout();
        run_txn("ext_timeout", 1'b1, 0, 1'b1, 0, 1'b0, 0, 2, 2);
        run_txn("ext_rdy_at_timeout", 1'b1, 0, 1'b1, TO, 1'b0, 0, 1, 2);
        run_txn("ext_rdy_after_timeout", 1'b0, 0, 1'b1, TO + 1, 1'b0, 0, 1, 2);
    endtask

    task automatic test_abort();
        run_txn("abort_int_wait", 1'b1, 0, 1'b0, 0, 1'b1, 1, 0, 2);
        run_txn("abort_int_start", 1'b0, 0, 1'b0, 0, 1'b1, 0, 0, 2);
        run_txn("abort_ext_wait", 1'b1, 0, 1'b1, 0, 1'b1, 5, 0, 2);
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] exp_ack;
        exp_ack = {4'b0011, 3'b000, 1'b1};
        for (int e = 1; e <= 3 + 1 + WS; e++) begin
            @(negedge CLK);
            bus.AS_ = 1'b0;
            bus.CS_ = 1'b0;
            bus.DS_ = 1'b0;
            bus.R_W = 1'b1;
            bus.EXT = 1'b0;
            @(posedge CLK);
            #1;
        end
        n_tests++;
        if (outs() !== exp_ack) begin
            n_fail++;
            $display("FAIL mid_ack_before_reset got=%b expected=%b", outs(), exp_ack);
        end
        #2 RESET = 1'b1;
        #1;
        n_tests++;
        if (outs() !== O_IDLE) begin
            n_fail++;
            $display("FAIL mid_ack_reset got=%b expected=%b", outs(), O_IDLE);
        end
        @(negedge CLK);
        drive_idle();
        @(negedge CLK);
        RESET = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
            n_tests++;
            if (outs() !== O_IDLE) begin
                n_fail++;
                $display("FAIL after_mid_ack_reset got=%b expected=%b", outs(), O_IDLE);
            end
        end
        run_txn("after_reset_read", 1'b1, 0, 1'b0, 0, 1'b0, 0, 0, 2);
    endtask

    task automatic test_back_to_back();
        // tail = 0: the next AS_ falls while the previous cycle is in RELEASE
        run_txn("b2b_first", 1'b1, 0, 1'b0, 0, 1'b0, 0, 0, 0);
        run_txn("b2b_second", 1'b0, 1, 1'b0, 0, 1'b0, 0, 0, 0);
        run_txn("b2b_third", 1'b1, 0, 1'b1, 3, 1'b0, 0, 0, 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit rd, ext, abort;
            int d, rdy_at;
            rd     = 1'($urandom_range(0, 1));
            ext    = 1'($urandom_range(0, 1));
            d      = rd ? 0 : int'($urandom_range(0, 3));
            rdy_at = ext ? int'($urandom_range(0, TO + 2)) : 0;
            abort  = ($urandom_range(0, 4) == 0);
            run_txn("random", rd, d, ext, rdy_at, abort,
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_internal_read();
        test_internal_write();
        test_ext_read();
        test_timeout();
        test_abort();
        test_reset_mid_ack();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_target_sm.md
BUS_TARGET_SM -- requirements
Module: bus_target_sm

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 2, fixed wait cycles for internal register accesses (0..15).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, max cycles waiting on DEV_RDY before bus error (1..255).
REQ-003 The block SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port AS_  input  1  68030 address strobe, active low, asynchronous to CLK.
REQ-006 The block SHALL have port DS_  input  1  68030 data strobe, active low, asynchronous.
REQ-007 The block SHALL have port R_W  input  1  1 = read, 0 = write; valid while AS_ low.
REQ-008 The block SHALL have port CS_  input  1  decoded chip select for this target, active low; valid while AS_ low.
REQ-009 The block SHALL have port EXT  input  1  1 = access targets external peripheral paced by DEV_RDY; 0 = internal register.
REQ-010 The block SHALL have port DEV_RDY  input  1  external peripheral ready, active high, synchronous to CLK.
REQ-011 The block SHALL have ports DSACK0_ and DSACK1_  output  1 each  cycle acknowledge, active low; always driven together (32-bit port).
REQ-012 The block SHALL have port DSACK_OE  output  1  tristate enable for DSACK0_/DSACK1_/BERR_ pins.
REQ-013 The block SHALL have port BERR_  output  1  bus error, active low.
REQ-014 The block SHALL have ports RD_STB and WR_STB  output  1 each  one-cycle register read/write strobes.
REQ-015 The block SHALL have ports DLATCH  output  1  (capture write data) and DOE  output  1  (drive read data onto bus).

Function
REQ-016 AS_, DS_, CS_, R_W SHALL pass through a two-flop synchronizer; "_s" denotes second-stage values; the FSM uses only _s values.
REQ-017 States SHALL be IDLE, START, WAIT, ACK, ERR, RELEASE.
REQ-018 IDLE->START when AS_s=0, CS_s=0, and (R_W_s=1 or DS_s=0); otherwise remain IDLE.
REQ-019 START SHALL last exactly one cycle: RD_STB=1 if read, WR_STB=1 and DLATCH=1 if write; R_W_s and EXT captured here and held for the cycle.
REQ-020 START->WAIT if (EXT=0 and WAIT_STATES>0) or (EXT=1); START->ACK if EXT=0 and WAIT_STATES=0.
REQ-021 Internal WAIT SHALL last exactly WAIT_STATES cycles (4-bit down-counter), then ->ACK.
REQ-022 External WAIT SHALL go ->ACK on the first cycle DEV_RDY=1 (DEV_RDY=1 in the first WAIT cycle gives one-cycle WAIT); an 8-bit counter increments each WAIT cycle; on reaching TIMEOUT with DEV_RDY=0 ->ERR; DEV_RDY=1 in the same cycle as count=TIMEOUT SHALL take priority (->ACK).
REQ-023 ACK: DSACK0_=DSACK1_=0, DSACK_OE=1; hold until AS_s=1, then ->RELEASE.
REQ-024 ERR: BERR_=0, DSACK0_/DSACK1_=1, DSACK_OE=1; hold until AS_s=1, then ->RELEASE.
REQ-025 RELEASE SHALL last one cycle: DSACK0_/DSACK1_/BERR_=1 with DSACK_OE=1 (actively negate before tristate), then ->IDLE with DSACK_OE=0.
REQ-026 DOE SHALL be 1 from START through ACK for reads only; 0 in RELEASE, ERR, IDLE and on all writes.
REQ-027 AS_s=1 in START or WAIT (aborted cycle) SHALL go ->RELEASE with no DSACK or BERR_ assertion and no further strobes.
REQ-028 A new cycle SHALL NOT start until RELEASE completes; AS_ re-asserted during RELEASE is recognised from IDLE on the following evaluation.
REQ-029 All outputs SHALL be registered (no combinational path from inputs to outputs).
REQ-030 Latency: AS_/CS_ low before edge k -> START entered at edge k+2; ACK at edge k+3+WAIT_STATES for internal accesses.

Reset
REQ-031 RESET=1 SHALL immediately force state IDLE, counters 0, synchronizers to inactive (AS_s=DS_s=CS_s=1), DSACK0_=DSACK1_=BERR_=1, DSACK_OE=0, RD_STB=WR_STB=DLATCH=DOE=0.
REQ-032 RESET asserted mid-cycle SHALL abandon the cycle; after release the block waits for a fresh AS_ falling qualification from IDLE.

Verification
REQ-033 Internal read, WAIT_STATES=2: AS_=CS_=0, R_W=1 before edge k -> RD_STB high cycle k+2 only, DSACK0_/1_ low from edge k+5 until 2 edges after AS_ rises, then one high cycle, DSACK_OE low next.
REQ-034 Internal write, DS_ asserted 2 cycles after AS_ -> START delayed until DS_s=0; WR_STB and DLATCH one cycle; DOE stays 0.
REQ-035 External read, DEV_RDY rises after 5 WAIT cycles -> ACK on the edge after DEV_RDY sampled high; BERR_ stays 1.
REQ-036 External access, DEV_RDY stuck 0, TIMEOUT=8 -> BERR_ low after 8 WAIT cycles, DSACK never asserted, released via RELEASE after AS_ negates.
REQ-037 AS_ negated during WAIT -> RELEASE then IDLE, no DSACK/BERR_ pulse; RESET pulse during ACK -> all outputs inactive immediately, DSACK_OE=0.
